ws2812_wb_queue: RTL

- Wishbone-slave front end that sits directly upstream of the ws2812 LED driver.
- Buffers LED-update words written by the management SoC into a small FIFO.
- Drains the FIFO into the driver's rgb_data/led_num/write interface, one single-cycle write strobe at a time, with a guaranteed minimum gap between strobes.
- Instantiated inside the harness in place of the direct wishbone-to-ws2812 register path.

---
 rtl/ws2812_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/ws2812_wb_queue.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared definitions for the wishbone-fed ws2812 update queue:
// register offsets, status bit positions, drain FSM states and the PUSH word layout.
package ws2812_pkg;

    localparam logic [7:0] OFF_PUSH   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;

    localparam int ST_EMPTY_BIT = 8;
    localparam int ST_FULL_BIT  = 9;
    localparam int ST_OVF_BIT   = 10;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP
    } drain_state_t;

    typedef struct packed {
        logic [7:0]  led_num;
        logic [23:0] rgb;
    } push_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full or a pop while empty
// is ignored, and pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately left out of reset; only pointers and count
    // define validity, and an unreset array maps onto plain RAM/flops without reset muxes.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ws2812_wb_queue.sv
// Wishbone slave that queues LED-update words and feeds them to the ws2812 driver
// as single-cycle write strobes separated by at least WRITE_GAP idle cycles.
module ws2812_wb_queue
    import ws2812_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
    parameter int          DEPTH     = 8,
    parameter int          WRITE_GAP = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_dat_i,
    input  logic [31:0]            wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [23:0]            rgb_data,
    output logic [7:0]             led_num,
    output logic                   write,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam logic [7:0] GAP_LOAD = 8'(WRITE_GAP - 1);

    logic         hit;
    logic         accept;
    logic [7:0]   offset;
    logic         push_req;
    logic         ovf_set;
    logic         ovf_clr;
    logic         overflow;
    logic [31:0]  status_word;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_pop;
    logic [31:0]  fifo_dout;
    push_word_t   head;

    drain_state_t state, state_nx;
    logic [7:0]   gap_cnt, gap_cnt_nx;

    // A request still held during its own ack cycle must not be taken twice.
    assign hit      = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign accept   = hit && !wbs_ack_o;
    assign offset   = wbs_adr_i[7:0];
    assign push_req = accept && wbs_we_i && (offset == OFF_PUSH) && (wbs_sel_i == 4'hF);
    assign ovf_set  = push_req && fifo_full;
    assign ovf_clr  = accept && wbs_we_i && (offset == OFF_STATUS) &&
                      wbs_dat_i[ST_OVF_BIT] && wbs_sel_i[1];
    assign head     = push_word_t'(fifo_dout);

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (wbs_dat_i),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status_word               = 32'(fifo_level);
        status_word[ST_EMPTY_BIT] = fifo_empty;
        status_word[ST_FULL_BIT]  = fifo_full;
        status_word[ST_OVF_BIT]   = overflow;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            overflow  <= 1'b0;
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= (accept && !wbs_we_i && offset == OFF_STATUS) ? status_word : '0;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        gap_cnt_nx = gap_cnt;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_nx = STROBE;
                end
            end
            STROBE: begin
                gap_cnt_nx = GAP_LOAD;
                state_nx   = GAP;
            end
            GAP: begin
                // The last gap cycle doubles as IDLE so pulses land exactly WRITE_GAP+1 apart.
                if (gap_cnt == 8'd0) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_nx = STROBE;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    gap_cnt_nx = gap_cnt - 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gap_cnt  <= 8'd0;
            write    <= 1'b0;
            rgb_data <= '0;
            led_num  <= '0;
        end else begin
            state   <= state_nx;
            gap_cnt <= gap_cnt_nx;
            write   <= fifo_pop;
            if (fifo_pop) begin
                rgb_data <= head.rgb;
                led_num  <= head.led_num;
            end
        end
    end

endmodule
